ring_router_node: RTL

// - One node of the unidirectional flit ring between GPUs. Accepts 16-bit flits {dest[5:0], payload[9:0]}

---
 rtl/noc_pkg.sv | 22 ++
 rtl/flit_fifo.sv | 60 ++++++
 rtl/ring_router_node.sv | 135 +++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared flit-ring definitions: flit field widths, field extraction and the
// destination validity rule used by every ring node.
package noc_pkg;

    localparam int FLIT_W    = 16;
    localparam int DEST_W    = 6;
    localparam int PAYLOAD_W = 10;

    function automatic logic [DEST_W-1:0] flit_dest(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_W-1 -: DEST_W];
    endfunction

    function automatic logic [PAYLOAD_W-1:0] flit_payload(input logic [FLIT_W-1:0] flit);
        return flit[PAYLOAD_W-1:0];
    endfunction

    // Ring addresses run 1..num_nodes; zero is never a node.
    function automatic logic dest_is_valid(input logic [DEST_W-1:0] dest, input int num_nodes);
        return (dest != '0) && (int'(dest) <= num_nodes);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous show-ahead flit queue: head_data is the oldest entry whenever
// empty is low. Push is ignored when full, pop is ignored when empty.
module flit_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         ACLK,
    input  logic         ARESETn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge ACLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ring_router_node.sv
// One node of the unidirectional GPU flit ring: merges local injection into the
// ring, ejects flits addressed to this node, drops injected flits with bad dest.
module ring_router_node #(
    parameter int NODE_ID      = 16,
    parameter int NUM_NODES    = 32,
    parameter int FLIT_W       = 16,
    parameter int INJ_DEPTH    = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [FLIT_W-1:0] inj_data,
    input  logic              inj_valid,
    output logic              inj_ready,
    output logic [FLIT_W-1:0] ej_data,
    output logic              ej_valid,
    input  logic              ej_ready,
    input  logic [FLIT_W-1:0] ring_in_data,
    input  logic              ring_in_valid,
    output logic              ring_in_ready,
    output logic [FLIT_W-1:0] ring_out_data,
    output logic              ring_out_valid,
    input  logic              ring_out_ready,
    output logic [7:0]        drop_cnt
);

    import noc_pkg::*;

    // Handshakes: a flit moves on a rising edge where valid && ready; a source
    // keeps data stable while valid is high and unaccepted, and the output
    // registers here obey the same rule toward downstream and the local GPU.

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [DEST_W-1:0] MY_ID     = DEST_W'(NODE_ID);
    localparam logic [SW-1:0]     STARVE_MX = SW'(STARVE_LIMIT);

    logic [FLIT_W-1:0] head_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [SW-1:0]     starve_cnt;
    logic [DEST_W-1:0] ring_dest;
    logic [DEST_W-1:0] head_dest;

    logic out_free, ej_free;
    logic ring_ej, head_ej, head_ring, head_drop, forced_inject;
    logic ring_to_out, ring_to_ej, head_to_out, head_to_ej, head_lost;

    flit_fifo #(
        .W     (FLIT_W),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .push      (inj_valid),
        .push_data (inj_data),
        .pop       (fifo_pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign inj_ready = !fifo_full;
    assign ring_dest = ring_in_data[FLIT_W-1 -: DEST_W];
    assign head_dest = head_data[FLIT_W-1 -: DEST_W];

    assign out_free = !ring_out_valid || ring_out_ready;
    assign ej_free  = !ej_valid || ej_ready;

    assign ring_ej   = (ring_dest == MY_ID);
    assign head_drop = !fifo_empty && !dest_is_valid(head_dest, NUM_NODES);
    assign head_ej   = !fifo_empty && !head_drop && (head_dest == MY_ID);
    assign head_ring = !fifo_empty && !head_drop && (head_dest != MY_ID);

    // A starved head takes ring_out this cycle and ring-bound ring_in is held off.
    assign forced_inject = head_ring && out_free && (starve_cnt == STARVE_MX);
    assign ring_in_ready = ring_ej ? ej_free : (out_free && !forced_inject);

    assign ring_to_out = ring_in_valid && !ring_ej && ring_in_ready;
    assign ring_to_ej  = ring_in_valid && ring_ej && ring_in_ready;
    assign head_to_out = head_ring && out_free && !ring_to_out;
    assign head_lost   = head_ring && out_free && ring_to_out;
    assign head_to_ej  = head_ej && ej_free && !(ring_in_valid && ring_ej);
    assign fifo_pop    = head_to_out || head_to_ej || head_drop;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ring_out_valid <= 1'b0;
            ring_out_data  <= '0;
        end else if (ring_to_out) begin
            ring_out_valid <= 1'b1;
            ring_out_data  <= ring_in_data;
        end else if (head_to_out) begin
            ring_out_valid <= 1'b1;
            ring_out_data  <= head_data;
        end else if (ring_out_ready) begin
            ring_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ej_valid <= 1'b0;
            ej_data  <= '0;
        end else if (ring_to_ej) begin
            ej_valid <= 1'b1;
            ej_data  <= ring_in_data;
        end else if (head_to_ej) begin
            ej_valid <= 1'b1;
            ej_data  <= head_data;
        end else if (ej_ready) begin
            ej_valid <= 1'b0;
        end
    end

    // Starvation counts only real losses of a ring-bound head to ring_in.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            starve_cnt <= '0;
        end else if (head_to_out) begin
            starve_cnt <= '0;
        end else if (head_lost && (starve_cnt != STARVE_MX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            drop_cnt <= '0;
        end else if (head_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
